// File: rtl/memory_unit_if.sv
// Memory bus between the controller and memory_unit: the read/write bus plus
// the streaming program-load port.
interface memory_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              memory_enable_bus;
  logic              memory_load_bus;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] data_out;
  logic              op;
  logic              prog_en;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_wrapped;

  modport master (
    output address, write, memory_enable_bus, memory_load_bus, bus_in,
    output prog_en, prog_valid, prog_data,
    input  data_out, op, prog_ready, prog_wrapped
  );

  modport slave (
    input  address, write, memory_enable_bus, memory_load_bus, bus_in,
    input  prog_en, prog_valid, prog_data,
    output data_out, op, prog_ready, prog_wrapped
  );
endinterface

// File: rtl/memory_unit.sv
// Memory-side responder: latency-counted reads with op/consume handshake,
// write-first commits from the register bank, and a streaming program loader.
module memory_unit #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  memory_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, VALID, PROG} state_t;

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [2:0]        LAT_LAST   = 3'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_LAST   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] raddr_r, raddr_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [2:0]        cnt_r, cnt_s;
  logic [DATA_W-1:0] data_out_r, data_out_s;
  logic              op_r, op_s;
  logic              prog_ready_r, prog_ready_s;
  logic              prog_wrapped_r, prog_wrapped_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Next-state, output and array-write decode in priority order prog_en > write > load > read.
  always_comb begin
    state_s        = state_r;
    raddr_s        = raddr_r;
    ptr_s          = ptr_r;
    cnt_s          = cnt_r;
    data_out_s     = data_out_r;
    op_s           = op_r;
    prog_ready_s   = prog_ready_r;
    prog_wrapped_s = prog_wrapped_r;
    mem_we_s       = 1'b0;
    mem_waddr_s    = bus.address;
    mem_wdata_s    = bus.bus_in;

    if (state_r == PROG) begin
      op_s = 1'b0;
      if (bus.prog_en) begin
        prog_ready_s = 1'b1;
        if (bus.prog_valid && prog_ready_r) begin
          mem_we_s       = 1'b1;
          mem_waddr_s    = ptr_r;
          mem_wdata_s    = bus.prog_data;
          ptr_s          = ptr_r + ADDR_ONE;
          prog_wrapped_s = prog_wrapped_r | (ptr_r == PTR_LAST);
        end else begin
          ptr_s = ptr_r;
        end
      end else begin
        // A word offered while prog_en falls is dropped on purpose.
        prog_ready_s = 1'b0;
        ptr_s        = ADDR_ZERO;
        state_s      = IDLE;
      end
    end else if (bus.prog_en) begin
      state_s      = PROG;
      prog_ready_s = 1'b1;
      op_s         = 1'b0;
    end else if (bus.write || bus.memory_load_bus) begin
      // Write-first: the restarted read samples the array after this edge's commit.
      mem_we_s = bus.write;
      op_s     = 1'b0;
      state_s  = READ;
      raddr_s  = bus.address;
      cnt_s    = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          raddr_s = bus.address;
          cnt_s   = 3'd0;
          state_s = READ;
        end
        READ: begin
          if (bus.address != raddr_r) begin
            raddr_s = bus.address;
            cnt_s   = 3'd0;
          end else if (cnt_r == LAT_LAST) begin
            data_out_s = mem_r[raddr_r];
            op_s       = 1'b1;
            state_s    = VALID;
          end else begin
            cnt_s = cnt_r + 3'd1;
          end
        end
        VALID: begin
          if (bus.memory_enable_bus || (bus.address != raddr_r)) begin
            op_s    = 1'b0;
            raddr_s = bus.address;
            cnt_s   = 3'd0;
            state_s = READ;
          end else begin
            op_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Control and output registers; array contents are deliberately outside reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      raddr_r        <= ADDR_ZERO;
      ptr_r          <= ADDR_ZERO;
      cnt_r          <= 3'd0;
      data_out_r     <= DATA_ZERO;
      op_r           <= 1'b0;
      prog_ready_r   <= 1'b0;
      prog_wrapped_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      raddr_r        <= raddr_s;
      ptr_r          <= ptr_s;
      cnt_r          <= cnt_s;
      data_out_r     <= data_out_s;
      op_r           <= op_s;
      prog_ready_r   <= prog_ready_s;
      prog_wrapped_r <= prog_wrapped_s;
    end
  end

  // Array write port; an edge seen while reset is high never commits.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.op           = op_r;
  assign bus.prog_ready   = prog_ready_r;
  assign bus.prog_wrapped = prog_wrapped_r;
endmodule
